// File: rtl/i2c_master_controller_pkg.sv
// Shared definitions for the I2C master sequencer: state encoding, per-state
// tick budgets and the half-period floor used by the bit-rate divider.
package i2c_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_ADDR  = 3'd2;
    localparam state_t ST_AACK  = 3'd3;
    localparam state_t ST_DATA  = 3'd4;
    localparam state_t ST_DACK  = 3'd5;
    localparam state_t ST_STOP  = 3'd6;

    localparam logic [4:0] TICKS_START = 5'd1;
    localparam logic [4:0] TICKS_ADDR  = 5'd16;
    localparam logic [4:0] TICKS_AACK  = 5'd2;
    localparam logic [4:0] TICKS_DATA  = 5'd16;
    localparam logic [4:0] TICKS_DACK  = 5'd2;
    localparam logic [4:0] TICKS_STOP  = 5'd2;

    localparam logic [29:0] HALF_PERIOD_MIN = 30'd1;

    // Index of the final tick spent in a state (tick budget minus one).
    function automatic logic [3:0] last_idx(input state_t s);
        logic [4:0] n;
        case (s)
            ST_START: n = TICKS_START;
            ST_ADDR:  n = TICKS_ADDR;
            ST_AACK:  n = TICKS_AACK;
            ST_DATA:  n = TICKS_DATA;
            ST_DACK:  n = TICKS_DACK;
            ST_STOP:  n = TICKS_STOP;
            default:  n = 5'd1;
        endcase
        return 4'(n - 5'd1);
    endfunction

endpackage

// File: rtl/i2c_master_controller_if.sv
// Bundle of user-side request lines and data-unit control lines around the
// I2C master sequencer.
interface i2c_master_controller_if;
    logic        Go;
    logic        RW;
    logic [6:0]  SlaveAddress;
    logic [7:0]  TxData;
    logic [19:0] BaudRate;
    logic [29:0] ClockFrequency;
    logic        SDAIn;
    logic        SCL;
    logic [7:0]  SentData;
    logic        WriteLoad;
    logic        ReadorWrite;
    logic        ShiftorHold;
    logic        Select;
    logic        StartStopAck;
    logic        Busy;
    logic        Done;
    logic        AckError;

    modport master (
        input  Go, RW, SlaveAddress, TxData, BaudRate, ClockFrequency, SDAIn,
        output SCL, SentData, WriteLoad, ReadorWrite, ShiftorHold, Select,
               StartStopAck, Busy, Done, AckError
    );

    modport slave (
        output Go, RW, SlaveAddress, TxData, BaudRate, ClockFrequency, SDAIn,
        input  SCL, SentData, WriteLoad, ReadorWrite, ShiftorHold, Select,
               StartStopAck, Busy, Done, AckError
    );
endinterface

// File: rtl/i2c_master_controller_tick_gen.sv
// Half-period divider and tick counter; the divisor is captured when a
// transaction is accepted so rate changes mid-transfer have no effect.
module i2c_tick_gen
    import i2c_pkg::*;
(
    input  logic        clock,
    input  logic        Reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [19:0] baud_rate,
    input  logic [29:0] clock_frequency,
    output logic        tick
);

    logic [29:0] divisor;
    logic [29:0] quotient;
    logic [29:0] half_period;
    logic [29:0] half_period_reg;
    logic [29:0] count_reg;
    logic [29:0] count_next;

    always_comb begin
        divisor     = (baud_rate == 20'd0) ? 30'd1 : {9'd0, baud_rate, 1'b0};
        quotient    = (baud_rate == 20'd0) ? 30'd0 : clock_frequency / divisor;
        half_period = (quotient == 30'd0) ? HALF_PERIOD_MIN : quotient;
    end

    assign tick = enable && (count_reg == half_period_reg - 30'd1);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = 30'd0;
        end else if (enable) begin
            count_next = tick ? 30'd0 : count_reg + 30'd1;
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            count_reg       <= 30'd0;
            half_period_reg <= HALF_PERIOD_MIN;
        end else begin
            count_reg <= count_next;
            if (clear) begin
                half_period_reg <= half_period;
            end
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C transaction sequencer driving SCL and the data-unit controls.
// Line controls are decoded from state and tick index, so they only move on ticks.
module i2c_master_controller
    import i2c_pkg::*;
(
    input  logic                   clock,
    input  logic                   Reset,
    i2c_master_controller_if.master bus
);

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        load_reg, load_next;
    logic        shift_reg, shift_next;
    logic        ack_err_reg, ack_err_next;
    logic        rw_reg, rw_next;
    logic [7:0]  tx_reg, tx_next;
    logic [7:0]  sent_reg, sent_next;
    logic        accept;
    logic        tick;
    logic        last_tick;
    logic        scl_c, select_c, ssa_c, row_c;

    i2c_tick_gen u_tick_gen (
        .clock           (clock),
        .Reset           (Reset),
        .clear           (accept),
        .enable          (busy_reg),
        .baud_rate       (bus.BaudRate),
        .clock_frequency (bus.ClockFrequency),
        .tick            (tick)
    );

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 4'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            load_reg    <= 1'b0;
            shift_reg   <= 1'b0;
            ack_err_reg <= 1'b0;
            rw_reg      <= 1'b0;
            tx_reg      <= 8'd0;
            sent_reg    <= 8'd0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            load_reg    <= load_next;
            shift_reg   <= shift_next;
            ack_err_reg <= ack_err_next;
            rw_reg      <= rw_next;
            tx_reg      <= tx_next;
            sent_reg    <= sent_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        load_next    = 1'b0;
        shift_next   = 1'b0;
        ack_err_next = ack_err_reg;
        rw_next      = rw_reg;
        tx_next      = tx_reg;
        sent_next    = sent_reg;
        accept       = 1'b0;
        last_tick    = tick && (idx_reg == last_idx(state_reg));

        if (state_reg != ST_IDLE && tick) begin
            idx_next = last_tick ? 4'd0 : idx_reg + 4'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                // The Done cycle is still IDLE; a Go seen there must wait a cycle.
                if (bus.Go && !done_reg) begin
                    accept       = 1'b1;
                    rw_next      = bus.RW;
                    tx_next      = bus.TxData;
                    sent_next    = {bus.SlaveAddress, bus.RW};
                    load_next    = 1'b1;
                    busy_next    = 1'b1;
                    ack_err_next = 1'b0;
                    idx_next     = 4'd0;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (last_tick) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                shift_next = tick && idx_reg[0] && !last_tick;
                if (last_tick) state_next = ST_AACK;
            end
            ST_AACK: begin
                if (tick && !idx_reg[0] && bus.SDAIn) ack_err_next = 1'b1;
                if (last_tick) begin
                    if (ack_err_reg) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_DATA;
                        if (!rw_reg) begin
                            sent_next = tx_reg;
                            load_next = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                // Reads shift on rising SCL; writes shift on falling SCL.
                if (rw_reg) shift_next = tick && !idx_reg[0];
                else        shift_next = tick && idx_reg[0] && !last_tick;
                if (last_tick) state_next = ST_DACK;
            end
            ST_DACK: begin
                if (tick && !rw_reg && !idx_reg[0] && bus.SDAIn) ack_err_next = 1'b1;
                if (last_tick) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (last_tick) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = 4'd0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_comb begin
        scl_c    = 1'b1;
        select_c = 1'b0;
        ssa_c    = 1'b1;
        row_c    = 1'b1;
        case (state_reg)
            ST_START: ssa_c = 1'b0;
            ST_ADDR: begin
                scl_c    = idx_reg[0];
                select_c = 1'b1;
            end
            ST_AACK: begin
                scl_c    = idx_reg[0];
                select_c = 1'b1;
                row_c    = 1'b0;
            end
            ST_DATA: begin
                scl_c    = idx_reg[0];
                select_c = 1'b1;
                row_c    = ~rw_reg;
            end
            ST_DACK: begin
                scl_c    = idx_reg[0];
                select_c = ~rw_reg;
                row_c    = rw_reg;
            end
            ST_STOP: begin
                scl_c = idx_reg[0];
                ssa_c = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.SCL          = scl_c;
    assign bus.Select       = select_c;
    assign bus.StartStopAck = ssa_c;
    assign bus.ReadorWrite  = row_c;
    assign bus.WriteLoad    = load_reg;
    assign bus.ShiftorHold  = shift_reg;
    assign bus.SentData     = sent_reg;
    assign bus.Busy         = busy_reg;
    assign bus.Done         = done_reg;
    assign bus.AckError     = ack_err_reg;

endmodule

// File: doc/i2c_master_controller.md
# i2c_master_controller

Sequencer for the Lab7 I2C data unit. It generates SCL and drives the unit's control lines (WriteLoad, ReadorWrite, ShiftorHold, Select, StartStopAck) and its SentData bus. A complete single-byte transaction is START, address+R/W, slave ACK, one data byte (write, or read with master NACK), then STOP. It sits between the lab's top-level user logic and I2C_DataUnit.

## Interface
- No parameters; bit rate is set at run time from BaudRate and ClockFrequency.
- clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Go  in  1  start request; sampled only in IDLE
- RW  in  1  1 = read, 0 = write; latched with Go
- SlaveAddress  in  7  latched with Go
- TxData  in  8  write byte; latched with Go
- BaudRate  in  20  SCL rate
- ClockFrequency  in  30  clock rate, same units as BaudRate
- SDAIn  in  1  resolved SDA line, for ACK sampling
- SCL  out  1  I2C clock
- SentData  out  8  to data unit
- WriteLoad, ReadorWrite, ShiftorHold, Select, StartStopAck  out  1 each  data-unit controls
- Busy  out  1  transaction in progress
- Done  out  1  one-cycle completion pulse
- AckError  out  1  slave NACKed; held until next Go

## Operation
- Data-unit control semantics:
  - WriteLoad=1 loads SentData.
  - ReadorWrite=1 means the unit drives SDA; 0 releases SDA.
  - Select=1 puts the shift-register MSB on SDA; Select=0 puts StartStopAck on SDA.
  - ShiftorHold=1 shifts one bit.
- HalfPeriod = ClockFrequency / (2·BaudRate), integer division. If BaudRate=0 or the quotient is 0, HalfPeriod=1.
- tick: one-cycle pulse every HalfPeriod cycles while Busy. The counter restarts at Go acceptance.
- States and tick counts:
  - IDLE. Go=1 → latch inputs and set Busy. Drive SentData={SlaveAddress,RW} and WriteLoad=1 for one cycle. Clear AckError. Go to START.
  - START, 1 tick: SCL=1, Select=0, StartStopAck=0.
  - ADDR, 16 ticks: 8 bits × (SCL low tick, SCL high tick). Select=1, ReadorWrite=1. ShiftorHold pulses for 1 cycle on each high→low tick except the last.
  - AACK, 2 ticks: ReadorWrite=0. SDAIn is sampled on the rising-SCL tick; 1 → AckError=1, then go to STOP.
  - On entering DATA for a write: SentData=TxData, WriteLoad pulses for 1 cycle.
  - DATA, 16 ticks:
    - Write: same as ADDR.
    - Read: ReadorWrite=0, and ShiftorHold pulses on each rising-SCL tick (8 pulses).
  - DACK, 2 ticks:
    - Write: as AACK.
    - Read: master drives NACK (ReadorWrite=1, Select=0, StartStopAck=1).
  - STOP, 2 ticks: SCL low with SDA low, then SCL high with SDA low. On the cycle after the last tick: StartStopAck=1, Done=1 for 1 cycle, Busy=0, return to IDLE.
- Go while Busy is ignored. Inputs changing mid-transaction are ignored (latched copies are used).

## Timing
- Reset values, applied immediately on assertion, including mid-transaction:
  - SCL=1, Select=0, StartStopAck=1, ReadorWrite=1
  - WriteLoad=0, ShiftorHold=0, SentData=0
  - Busy=0, Done=0, AckError=0
  - state IDLE
- SCL is released to 1 on reset; no STOP is generated.
- Go sampled at edge N. Busy=1 from N+1. The first tick is at N+HalfPeriod.
- Full transaction = 39 ticks. Done is at cycle N+39·HalfPeriod+1.
- NACK in AACK skips DATA and DACK. Done is then at N+21·HalfPeriod+1.
- Go coincident with a Done cycle is ignored; Go is accepted from the following cycle.
- SCL and SDA controls change only on tick cycles, so SDA never changes while SCL=1 except in START and STOP.

## Structure
- Shared package i2c_pkg holds:
  - state encoding localparams (IDLE, START, ADDR, AACK, DATA, DACK, STOP)
  - tick counts per state (1, 16, 2, 16, 2, 2)
  - the HalfPeriod minimum
- One sub-module, i2c_tick_gen: divider computation plus the tick counter, with clear on Go.

## Test plan
- HalfPeriod=3 (BaudRate=2, ClockFrequency=12). Write addr 0x50, TxData 0xCA, slave ACKs → ShiftorHold pulses 7+7, Done at cycle N+118, AckError=0.
- Same setup, read, SDAIn=0 during both ACK windows → 8 read ShiftorHold pulses on rising SCL, NACK driven, Done at N+118.
- Address NACK (SDAIn=1 in AACK) → AckError=1, STOP follows, Done at N+64.
- BaudRate=0 → HalfPeriod=1, Done at N+40.
- Go pulsed at N+10 while Busy → ignored, single Done.
- Reset asserted mid-ADDR → all outputs at reset values in the same cycle; a new Go after release completes normally.
